// File: rtl/timer_pkg.sv
// Shared constants and types for the 8-bit timer APB register interface.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;

  // TCR bits 6, 3 and 2 are unimplemented and always read 0.
  localparam logic [7:0] TCR_WMASK = 8'hB3;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/timer_apb_regif_if.sv
// APB3 bus bundle between the interconnect (master) and the timer register block (slave).
interface timer_apb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/timer_apb_fsm.sv
// APB3 transfer tracker: follows SETUP/ACCESS, inserts WAIT_CYCLES wait states,
// and raises pready for exactly one cycle on the completing ACCESS cycle.
module timer_apb_fsm
  import timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic preset,
  input  logic psel,
  input  logic penable,
  output logic pready
);

  localparam logic [2:0] WAIT_MAX = 3'(WAIT_CYCLES);

  apb_state_e state, state_next;
  logic [2:0] wait_cnt, wait_cnt_next;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pready        = 1'b0;
    unique case (state)
      IDLE: begin
        wait_cnt_next = '0;
        if (psel && !penable) state_next = SETUP;
      end
      SETUP: begin
        state_next = psel ? ACCESS : IDLE;
      end
      ACCESS: begin
        // A master dropping psel abandons the transfer without completing it.
        if (!psel) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_MAX) begin
          pready        = 1'b1;
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/timer_apb_regif.sv
// Timer APB3 completer: decodes TDR/TCR/TSR, drives counter controls, latches wrap events.
// Optional macro TIMER_APB_SLVERR_EN enables pslverr on unmapped or read-only-bit accesses.
module timer_apb_regif
  import timer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       pclk,
  input  logic       preset,
  timer_apb_if.slave apb,
  output logic [7:0] tdr_o,
  output logic       load_o,
  output logic       updw_o,
  output logic       en_o,
  output logic [1:0] cks_o,
  input  logic       ovf_set_i,
  input  logic       udf_set_i,
  output logic       tmr_int_o
);

  logic              pready;
  logic              wr_done;
  logic              sel_tdr, sel_tcr, sel_tsr;
  logic [7:0]        tdr, tcr;
  logic [1:0]        tsr, tsr_next;
  logic [DATA_W-1:0] rdata;

  timer_apb_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_fsm (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (apb.psel),
    .penable (apb.penable),
    .pready  (pready)
  );

  assign sel_tdr = (apb.paddr == ADDR_W'(ADDR_TDR));
  assign sel_tcr = (apb.paddr == ADDR_W'(ADDR_TCR));
  assign sel_tsr = (apb.paddr == ADDR_W'(ADDR_TSR));
  assign wr_done = pready && apb.pwrite;

  // Write-0-to-clear, then OR in the event pulses so a coincident set wins.
  always_comb begin
    tsr_next = tsr;
    if (wr_done && sel_tsr) tsr_next = tsr & apb.pwdata[1:0];
    tsr_next[TSR_OVF] = tsr_next[TSR_OVF] | ovf_set_i;
    tsr_next[TSR_UDF] = tsr_next[TSR_UDF] | udf_set_i;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr <= '0;
      tcr <= '0;
      tsr <= '0;
    end else begin
      if (wr_done && sel_tdr) tdr <= apb.pwdata[7:0];
      if (wr_done && sel_tcr) tcr <= apb.pwdata[7:0] & TCR_WMASK;
      tsr <= tsr_next;
    end
  end

  always_comb begin
    rdata = '0;
    if (pready && !apb.pwrite) begin
      if (sel_tdr)      rdata = DATA_W'(tdr);
      else if (sel_tcr) rdata = DATA_W'(tcr);
      else if (sel_tsr) rdata = DATA_W'({6'b0, tsr});
    end
  end

  assign apb.prdata = rdata;
  assign apb.pready = pready;

`ifdef TIMER_APB_SLVERR_EN
  logic unmapped, ro_write;
  assign unmapped    = !(sel_tdr || sel_tcr || sel_tsr);
  assign ro_write    = sel_tsr && apb.pwrite && (|apb.pwdata[7:2]);
  assign apb.pslverr = pready && (unmapped || ro_write);
`else
  assign apb.pslverr = 1'b0;
`endif

  assign tdr_o     = tdr;
  assign load_o    = tcr[7];
  assign updw_o    = tcr[5];
  assign en_o      = tcr[4];
  assign cks_o     = tcr[1:0];
  assign tmr_int_o = |tsr;

endmodule

// File: tb/tb_timer_apb_regif.sv
// Self-checking bench for timer_apb_regif: a zero-wait instance for register behaviour
// and a WAIT_CYCLES=3 instance for wait-state timing; reads are scored through a queue.
module tb_timer_apb_regif;
  import timer_pkg::*;

`ifdef TIMER_APB_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  timer_apb_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  timer_apb_if #(.ADDR_W(8), .DATA_W(8)) bus_w ();

  logic [7:0] tdr_o, tdr_w;
  logic       load_o, updw_o, en_o, tmr_int_o;
  logic [1:0] cks_o;
  logic       load_w, updw_w, en_w, int_w;
  logic [1:0] cks_w;
  logic       ovf_set = 1'b0;
  logic       udf_set = 1'b0;

  timer_apb_regif #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut (
    .pclk(pclk), .preset(preset), .apb(bus),
    .tdr_o(tdr_o), .load_o(load_o), .updw_o(updw_o), .en_o(en_o), .cks_o(cks_o),
    .ovf_set_i(ovf_set), .udf_set_i(udf_set), .tmr_int_o(tmr_int_o)
  );

  timer_apb_regif #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3)) u_dut_w (
    .pclk(pclk), .preset(preset), .apb(bus_w),
    .tdr_o(tdr_w), .load_o(load_w), .updw_o(updw_w), .en_o(en_w), .cks_o(cks_w),
    .ovf_set_i(1'b0), .udf_set_i(1'b0), .tmr_int_o(int_w)
  );

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  string      tag_q[$];

  task automatic drive(input int which, input logic sel, input logic en, input logic wr,
                       input logic [7:0] addr, input logic [7:0] data);
    if (which == 0) begin
      bus.psel = sel; bus.penable = en; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = data;
    end else begin
      bus_w.psel = sel; bus_w.penable = en; bus_w.pwrite = wr; bus_w.paddr = addr; bus_w.pwdata = data;
    end
  endtask

  task automatic sample(input int which, output logic rdy, output logic [7:0] rd, output logic e);
    if (which == 0) begin
      rdy = bus.pready; rd = bus.prdata; e = bus.pslverr;
    end else begin
      rdy = bus_w.pready; rd = bus_w.prdata; e = bus_w.pslverr;
    end
  endtask

  // Starts and ends at posedge+#1 so consecutive calls run back-to-back.
  // lows counts penable cycles with pready=0; the first of them is the FSM SETUP cycle.
  task automatic apb_xfer(input int which, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic ovf_at_done,
                          output logic [7:0] rdata, output logic err, output int lows,
                          output logic idle_zero);
    logic rdy;
    logic [7:0] rd;
    logic e;
    rdy = 1'b0; rdata = '0; err = 1'b0; lows = 0; idle_zero = 1'b1;
    drive(which, 1'b1, 1'b0, wr, addr, wdata);
    @(posedge pclk); #1;
    drive(which, 1'b1, 1'b1, wr, addr, wdata);
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      sample(which, rdy, rd, e);
      if (rdy) begin
        rdata = rd;
        err   = e;
        if (ovf_at_done) ovf_set = 1'b1;
        break;
      end
      lows++;
      if (rd !== 8'h00) idle_zero = 1'b0;
      @(posedge pclk); #1;
    end
    if (!rdy) begin
      checks++;
      $display("FAIL timeout: pready=%b after 20 cycles, required 1 (addr %h)", rdy, addr);
    end
    @(posedge pclk); #1;
    ovf_set = 1'b0;
    drive(which, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic apb_write(input int which, input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] rd; logic err; int lows; logic iz;
    apb_xfer(which, 1'b1, addr, data, 1'b0, rd, err, lows, iz);
  endtask

  task automatic issue_read(input int which, input logic [7:0] addr, input logic [7:0] exp,
                            input string tag);
    logic [7:0] rd; logic err; int lows; logic iz;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    apb_xfer(which, 1'b0, addr, 8'h00, 1'b0, rd, err, lows, iz);
    got_q.push_back(rd);
  endtask

  task automatic pulse(input logic ovf, input logic udf);
    ovf_set = ovf; udf_set = udf;
    @(posedge pclk); #1;
    ovf_set = 1'b0; udf_set = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e8, g8; string t;
    @(negedge pclk);
    checks++;
    if ({bus.pready, bus.pslverr, bus.prdata} !== 10'h000)
      $display("FAIL reset_bus: pready/pslverr/prdata=%h required 000", {bus.pready, bus.pslverr, bus.prdata});
    else passes++;
    checks++;
    if ({tdr_o, load_o, updw_o, en_o, cks_o, tmr_int_o} !== 14'h0)
      $display("FAIL reset_ctrl: outputs=%h required 0000", {tdr_o, load_o, updw_o, en_o, cks_o, tmr_int_o});
    else passes++;
    @(posedge pclk); #1;
    preset = 1'b0;
    apb_write(0, ADDR_TDR, 8'h5A);
    apb_write(0, ADDR_TCR, 8'hB3);
    pulse(1'b1, 1'b1);
    // Enter ACCESS, then reset before the completing edge.
    drive(0, 1'b1, 1'b0, 1'b1, ADDR_TDR, 8'hC3);
    @(posedge pclk); #1;
    drive(0, 1'b1, 1'b1, 1'b1, ADDR_TDR, 8'hC3);
    @(posedge pclk); #1;
    checks++;
    if (bus.pready !== 1'b1) $display("FAIL pre_reset_access: pready=%b required 1", bus.pready);
    else passes++;
    preset = 1'b1;
    #1;
    checks++;
    if (bus.pready !== 1'b0) $display("FAIL reset_mid_access: pready=%b required 0", bus.pready);
    else passes++;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge pclk); #1;
    preset = 1'b0;
    checks++;
    if ({tdr_o, load_o, updw_o, en_o, cks_o, tmr_int_o} !== 14'h0)
      $display("FAIL reset_ctrl_after: outputs=%h required 0000", {tdr_o, load_o, updw_o, en_o, cks_o, tmr_int_o});
    else passes++;
    issue_read(0, ADDR_TDR, 8'h00, "reset_tdr");
    issue_read(0, ADDR_TCR, 8'h00, "reset_tcr");
    issue_read(0, ADDR_TSR, 8'h00, "reset_tsr");
    while (exp_q.size() != 0) begin
      e8 = exp_q.pop_front(); g8 = got_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (g8 !== e8) $display("FAIL %s: prdata=%h required %h", t, g8, e8);
      else passes++;
    end
  endtask

  task automatic test_tdr_tcr();
    logic [7:0] e8, g8; string t;
    apb_write(0, ADDR_TDR, 8'h35);
    issue_read(0, ADDR_TDR, 8'h35, "tdr_read");
    checks++;
    if (tdr_o !== 8'h35) $display("FAIL tdr_o: got %h required 35", tdr_o);
    else passes++;
    apb_write(0, ADDR_TCR, 8'h80);
    checks++;
    if ({load_o, updw_o, en_o, cks_o} !== 5'b10000)
      $display("FAIL tcr_80_ctrl: got %b required 10000", {load_o, updw_o, en_o, cks_o});
    else passes++;
    apb_write(0, ADDR_TCR, 8'h13);
    checks++;
    if ({load_o, updw_o, en_o, cks_o} !== 5'b00111)
      $display("FAIL tcr_13_ctrl: got %b required 00111", {load_o, updw_o, en_o, cks_o});
    else passes++;
    issue_read(0, ADDR_TCR, 8'h13, "tcr_13_read");
    apb_write(0, ADDR_TCR, 8'hFF);
    checks++;
    if ({load_o, updw_o, en_o, cks_o} !== 5'b11111)
      $display("FAIL tcr_ff_ctrl: got %b required 11111", {load_o, updw_o, en_o, cks_o});
    else passes++;
    issue_read(0, ADDR_TCR, 8'hB3, "tcr_ff_read");
    issue_read(0, ADDR_TDR, 8'h35, "tdr_hold");
    while (exp_q.size() != 0) begin
      e8 = exp_q.pop_front(); g8 = got_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (g8 !== e8) $display("FAIL %s: prdata=%h required %h", t, g8, e8);
      else passes++;
    end
  endtask

  task automatic test_tsr();
    logic [7:0] e8, g8, rd; string t; logic err; int lows; logic iz;
    pulse(1'b1, 1'b0);
    checks++;
    if (tmr_int_o !== 1'b1) $display("FAIL int_after_ovf: tmr_int_o=%b required 1", tmr_int_o);
    else passes++;
    issue_read(0, ADDR_TSR, 8'h01, "tsr_ovf");
    apb_write(0, ADDR_TSR, 8'h00);
    checks++;
    if (tmr_int_o !== 1'b0) $display("FAIL int_after_clear: tmr_int_o=%b required 0", tmr_int_o);
    else passes++;
    issue_read(0, ADDR_TSR, 8'h00, "tsr_cleared");
    pulse(1'b0, 1'b1);
    apb_write(0, ADDR_TSR, 8'h02);
    issue_read(0, ADDR_TSR, 8'h02, "tsr_w1_keeps");
    apb_xfer(0, 1'b1, ADDR_TSR, 8'hFC, 1'b0, rd, err, lows, iz);
    checks++;
    if (err !== SLVERR_EN) $display("FAIL tsr_ro_bits_err: pslverr=%b required %b", err, SLVERR_EN);
    else passes++;
    issue_read(0, ADDR_TSR, 8'h00, "tsr_ro_write_clears");
    // Set pulse coincident with a clearing write: the UDF bit clears, OVF wins.
    pulse(1'b1, 1'b1);
    apb_xfer(0, 1'b1, ADDR_TSR, 8'h00, 1'b1, rd, err, lows, iz);
    issue_read(0, ADDR_TSR, 8'h01, "tsr_set_priority");
    while (exp_q.size() != 0) begin
      e8 = exp_q.pop_front(); g8 = got_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (g8 !== e8) $display("FAIL %s: prdata=%h required %h", t, g8, e8);
      else passes++;
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] e8, g8, rd; string t; logic err; int lows; logic iz;
    apb_xfer(1, 1'b1, ADDR_TDR, 8'hA5, 1'b0, rd, err, lows, iz);
    exp_q.push_back(8'hA5);
    tag_q.push_back("wait_tdr_read");
    apb_xfer(1, 1'b0, ADDR_TDR, 8'h00, 1'b0, rd, err, lows, iz);
    got_q.push_back(rd);
    // One SETUP cycle plus three ACCESS wait states before completion.
    checks++;
    if (lows !== 4) $display("FAIL wait_latency: pready-low cycles=%0d required 4", lows);
    else passes++;
    checks++;
    if (iz !== 1'b1) $display("FAIL wait_prdata_idle: prdata zero while waiting=%b required 1", iz);
    else passes++;
    apb_xfer(0, 1'b0, ADDR_TDR, 8'h00, 1'b0, rd, err, lows, iz);
    checks++;
    if (lows !== 1) $display("FAIL nowait_latency: pready-low cycles=%0d required 1", lows);
    else passes++;
    while (exp_q.size() != 0) begin
      e8 = exp_q.pop_front(); g8 = got_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (g8 !== e8) $display("FAIL %s: prdata=%h required %h", t, g8, e8);
      else passes++;
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] e8, g8, rd; string t; logic err; int lows; logic iz;
    exp_q.push_back(8'h00);
    tag_q.push_back("unmapped_read");
    apb_xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, rd, err, lows, iz);
    got_q.push_back(rd);
    checks++;
    if (err !== SLVERR_EN) $display("FAIL unmapped_read_err: pslverr=%b required %b", err, SLVERR_EN);
    else passes++;
    apb_xfer(0, 1'b1, 8'hFF, 8'hFF, 1'b0, rd, err, lows, iz);
    checks++;
    if (err !== SLVERR_EN) $display("FAIL unmapped_write_err: pslverr=%b required %b", err, SLVERR_EN);
    else passes++;
    issue_read(0, ADDR_TDR, 8'h35, "unmapped_tdr_untouched");
    issue_read(0, ADDR_TCR, 8'hB3, "unmapped_tcr_untouched");
    apb_xfer(0, 1'b0, ADDR_TDR, 8'h00, 1'b0, rd, err, lows, iz);
    checks++;
    if (err !== 1'b0) $display("FAIL mapped_no_err: pslverr=%b required 0", err);
    else passes++;
    while (exp_q.size() != 0) begin
      e8 = exp_q.pop_front(); g8 = got_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (g8 !== e8) $display("FAIL %s: prdata=%h required %h", t, g8, e8);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e8, g8, rd; string t; logic err; int lows[4]; logic iz;
    apb_xfer(0, 1'b1, ADDR_TDR, 8'h11, 1'b0, rd, err, lows[0], iz);
    exp_q.push_back(8'h11); tag_q.push_back("b2b_tdr");
    apb_xfer(0, 1'b0, ADDR_TDR, 8'h00, 1'b0, rd, err, lows[1], iz);
    got_q.push_back(rd);
    apb_xfer(0, 1'b1, ADDR_TCR, 8'h35, 1'b0, rd, err, lows[2], iz);
    exp_q.push_back(8'h31); tag_q.push_back("b2b_tcr");
    apb_xfer(0, 1'b0, ADDR_TCR, 8'h00, 1'b0, rd, err, lows[3], iz);
    got_q.push_back(rd);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lows[i] !== 1) $display("FAIL b2b_latency_%0d: pready-low cycles=%0d required 1", i, lows[i]);
      else passes++;
    end
    while (exp_q.size() != 0) begin
      e8 = exp_q.pop_front(); g8 = got_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (g8 !== e8) $display("FAIL %s: prdata=%h required %h", t, g8, e8);
      else passes++;
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge pclk);
    #1;
    test_reset();
    test_tdr_tcr();
    test_tsr();
    test_wait_states();
    test_unmapped();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/timer_apb_regif.md
Name: timer_apb_regif

Overview:
- APB3 completer (responder) register interface of the 8-bit timer. It is the other end of the bench CPU model's write_data/read_data transactions.
- Decodes TDR, TCR and TSR, and drives the control fields to the counter core.
- Captures the counter's overflow/underflow events into sticky status bits.
- Sits between the APB interconnect and the timer counter core.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width (fixed at 8 for this timer).
- WAIT_CYCLES, 0, number of pready-low cycles inserted in ACCESS before completion (0..7).

Ports:
- pclk  in  1  APB / system clock.
- preset  in  1  reset, asynchronous, active-high.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  register address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- tdr_o  out  8  TDR value to the counter (reload value).
- load_o  out  1  TCR[7], load TDR into TCNT.
- updw_o  out  1  TCR[5]; 0 = count up, 1 = count down.
- en_o  out  1  TCR[4], count enable.
- cks_o  out  2  TCR[1:0], clock select: 00 = /2, 01 = /4, 10 = /8, 11 = /16.
- ovf_set_i  in  1  one-cycle pulse from the counter on 0xFF->0x00 wrap while counting up.
- udf_set_i  in  1  one-cycle pulse from the counter on 0x00->0xFF wrap while counting down.
- tmr_int_o  out  1  TSR[0] | TSR[1].

Behaviour:
- Register map:
  - 0x00 TDR: RW, all 8 bits.
  - 0x01 TCR: RW. Writable bits are 7, 5, 4, 1, 0; bits 6, 3, 2 read 0 and ignore writes.
  - 0x02 TSR: bit0 OVF, bit1 UDF, bits 7:2 read 0.
- Reset values: all registers 0x00; prdata=0, pready=0, pslverr=0, all control outputs 0.
- FSM states:
  - IDLE -> SETUP on psel & !penable.
  - SETUP -> ACCESS next cycle.
  - In ACCESS, a wait counter counts WAIT_CYCLES cycles with pready=0, then asserts pready=1 for exactly one cycle and returns to IDLE.
  - If psel deasserts mid-transfer, return to IDLE with no register update.
  - Back-to-back transfers: SETUP may be entered on the cycle after completion.
- Register writes and read capture happen only on the completing cycle, where pready=1 in ACCESS.
  - With WAIT_CYCLES=0, latency is 2 cycles from SETUP.
- prdata is valid only while pready=1; it is 0 otherwise.
- TSR is write-0-to-clear. Writing 0 to a bit clears it; writing 1 leaves it unchanged.
- Set priority: if ovf_set_i/udf_set_i coincides with a clearing TSR write, the bit ends at 1.
- Set pulses are captured in any state, including mid-transfer.
- TCR load bit is software-controlled and is not self-clearing; it holds until rewritten.
- An unmapped address (paddr > 0x02) completes normally with prdata=0, and writes are ignored.
- Reset asserted mid-transfer returns the FSM to IDLE immediately and clears all registers.

Optional Feature:
- TIMER_APB_SLVERR_EN:
  - Defined: an unmapped address asserts pslverr=1 together with pready. A write to a read-only TSR bit position (7:2 set in pwdata) also asserts pslverr=1 and applies the clear semantics to bits 1:0.
  - Undefined: pslverr is tied to 0.

Decomposition:
- Shared package timer_pkg holds:
  - Address constants ADDR_TDR=8'h00, ADDR_TCR=8'h01, ADDR_TSR=8'h02.
  - TCR_WMASK=8'hB3 and TSR bit indices.
  - A typedef for the APB FSM state enum (IDLE, SETUP, ACCESS).
- Sub-module timer_apb_fsm: generates SETUP/ACCESS tracking, the wait counter and pready. The top level contains decode and registers.

Test Plan:
- Reset: assert preset mid-ACCESS -> pready=0, TDR/TCR/TSR read 0x00 after release, all control outputs 0.
- Write TDR=0x35, then read 0x00 -> prdata=0x35, tdr_o=0x35. Write TCR=0x80 then 0x13 -> load_o=0, en_o=1, cks_o=2'b11; TCR reads 0x13. Write TCR=0xFF -> TCR reads 0xB3.
- Pulse ovf_set_i -> TSR reads 0x01 and tmr_int_o=1. Write TSR=0x00 -> TSR reads 0x00 and tmr_int_o=0. Pulse udf_set_i, write TSR=0x02 -> TSR still 0x02.
- Pulse ovf_set_i on the same cycle as a completing TSR=0x00 write -> TSR reads 0x01.
- WAIT_CYCLES=3: read TDR -> exactly 3 ACCESS cycles with pready=0, then 1 cycle with pready=1 and prdata valid.
- Read 0x05 -> prdata=0x00. With TIMER_APB_SLVERR_EN: pslverr=1 at completion. Without it: pslverr=0.
